// File: rtl/rcd_cfg_reg_bank_pkg.sv
// Shared types and constants for the RCD configuration register bank:
// IBI state encoding, special register addresses, lock keys and IBI payload format.
package rcd_cfg_pkg;

  typedef enum logic [1:0] {
    IBI_IDLE = 2'd0,
    IBI_REQ  = 2'd1,
    IBI_WAIT = 2'd2
  } ibi_state_t;

  localparam logic [7:0] ADDR_STATUS   = 8'h40;
  localparam logic [7:0] ADDR_EVT_PEND = 8'h41;
  localparam logic [7:0] ADDR_EVT_MASK = 8'h42;
  localparam logic [7:0] ADDR_LOCK     = 8'h7F;

  localparam logic [7:0] LOCK_KEY_SET = 8'hA5;
  localparam logic [7:0] LOCK_KEY_CLR = 8'h5A;

  localparam logic [3:0] IBI_PREFIX   = 4'hA;
  localparam logic [3:0] EVT_MASK_RST = 4'hF;

  // Payload sent with an In-Band Interrupt for a given event code.
  function automatic logic [7:0] ibi_payload(input logic [1:0] code);
    return {IBI_PREFIX, 2'b00, code};
  endfunction

endpackage

// File: rtl/rcd_cfg_reg_bank_if.sv
// Register-access and IBI handshake bundle between the I3C slave and the register bank.
interface rcd_cfg_reg_bank_if;

  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_write;
  logic       reg_read;
  logic [7:0] reg_rdata;
  logic       reg_ready;
  logic       ibi_request;
  logic       ibi_grant;
  logic [7:0] ibi_data;

  modport master (
    output reg_addr, reg_wdata, reg_write, reg_read, ibi_grant,
    input  reg_rdata, reg_ready, ibi_request, ibi_data
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_write, reg_read, ibi_grant,
    output reg_rdata, reg_ready, ibi_request, ibi_data
  );

endinterface

// File: rtl/rcd_cfg_reg_bank_evt_fifo.sv
// Small synchronous FIFO for queued event codes; a push on a full FIFO is dropped
// unless a pop happens in the same cycle, and the drop is reported for one cycle.
module rcd_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign drop  = push & ~wr_en;
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rcd_cfg_reg_bank.sv
// RCD configuration register bank: config/status registers behind a one-cycle
// register port, event capture into a FIFO, and the IBI request handshake.
module rcd_cfg_reg_bank
  import rcd_cfg_pkg::*;
#(
  parameter int NUM_CFG   = 32,
  parameter int EVT_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rcd_cfg_reg_bank_if.slave      bus,
  input  logic [3:0]             evt_in,
  output logic [NUM_CFG*8-1:0]   cfg_q,
  output logic                   err_flag
);

  localparam int         CFG_AW    = $clog2(NUM_CFG);
  localparam int         CNT_W     = $clog2(EVT_DEPTH) + 1;
  localparam logic [8:0] CFG_LIMIT = 9'(NUM_CFG);

  logic [7:0]        cfg_mem [NUM_CFG];
  logic [CFG_AW-1:0] cfg_idx;
  logic              lock;
  logic [3:0]        evt_mask;
  logic [3:0]        evt_pend;
  logic [3:0]        evt_prev;
  logic              overflow;
  logic              ready_q;
  logic [7:0]        rdata_q;
  logic [7:0]        rdata_next;
  logic [7:0]        status_byte;
  logic [2:0]        count3;

  logic is_cfg, is_status, is_pend, is_mask, is_lock, mapped;
  logic access, collide, rd_only;
  logic cfg_wr_en, err_set, err_clr, ovf_clr;

  logic [3:0] evt_rise, pend_clr, push_cand, push_oh;
  logic [1:0] push_code;
  logic       push_valid;

  logic [1:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty, fifo_drop, fifo_pop;

  ibi_state_t state, next_state;
  logic [7:0] ibi_data_q;
  logic [7:0] ibi_data_int;
  logic       ibi_busy;

  assign cfg_idx = bus.reg_addr[CFG_AW-1:0];

  // Address decode and access classification for the current strobe.
  always_comb begin
    is_cfg    = ({1'b0, bus.reg_addr} < CFG_LIMIT);
    is_status = (bus.reg_addr == ADDR_STATUS);
    is_pend   = (bus.reg_addr == ADDR_EVT_PEND);
    is_mask   = (bus.reg_addr == ADDR_EVT_MASK);
    is_lock   = (bus.reg_addr == ADDR_LOCK);
    mapped    = is_cfg | is_status | is_pend | is_mask | is_lock;
    access    = bus.reg_read | bus.reg_write;
    collide   = bus.reg_read & bus.reg_write;
    rd_only   = bus.reg_read & ~bus.reg_write;
    cfg_wr_en = bus.reg_write & is_cfg & ~lock;
    err_set   = collide | (access & ~mapped) | (bus.reg_write & is_cfg & lock);
    err_clr   = bus.reg_write & is_status & bus.reg_wdata[0];
    ovf_clr   = bus.reg_write & is_status & bus.reg_wdata[3];
    pend_clr  = (bus.reg_write && is_pend) ? bus.reg_wdata[3:0] : 4'h0;
  end

  always_comb begin
    count3 = '0;
    for (int i = 0; i < 3; i++) begin
      if (i < CNT_W) count3[i] = fifo_count[i];
    end
  end

  assign ibi_busy    = (state != IBI_IDLE);
  assign status_byte = {count3, fifo_full, overflow, lock, ibi_busy, err_flag};

  always_comb begin
    rdata_next = 8'h00;
    if (rd_only) begin
      if (is_cfg)         rdata_next = cfg_mem[cfg_idx];
      else if (is_status) rdata_next = status_byte;
      else if (is_pend)   rdata_next = {4'h0, evt_pend};
      else if (is_mask)   rdata_next = {4'h0, evt_mask};
      else if (is_lock)   rdata_next = {7'b0, lock};
      else                rdata_next = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        cfg_mem[i] <= 8'h00;
      end
    end else if (cfg_wr_en) begin
      cfg_mem[cfg_idx] <= bus.reg_wdata;
    end
  end

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_q
    assign cfg_q[8*g+7:8*g] = cfg_mem[g];
  end

  // Register port: response is registered so ready/rdata appear one cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      rdata_q  <= 8'h00;
      lock     <= 1'b0;
      evt_mask <= EVT_MASK_RST;
      err_flag <= 1'b0;
    end else begin
      ready_q  <= access;
      rdata_q  <= rdata_next;
      err_flag <= (err_flag & ~err_clr) | err_set;
      if (bus.reg_write && is_lock) begin
        if (bus.reg_wdata == LOCK_KEY_SET)      lock <= 1'b1;
        else if (bus.reg_wdata == LOCK_KEY_CLR) lock <= 1'b0;
      end
      if (bus.reg_write && is_mask) begin
        evt_mask <= bus.reg_wdata[3:0];
      end
    end
  end

  assign bus.reg_ready = ready_q;
  assign bus.reg_rdata = rdata_q;

  // Pending edges drain into the FIFO lowest code first; masked-out bits stay pending.
  always_comb begin
    evt_rise   = evt_in & ~evt_prev;
    push_cand  = evt_pend & evt_mask;
    push_oh    = push_cand & (~push_cand + 4'd1);
    push_valid = |push_cand;
    push_code  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (push_cand[i]) push_code = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_prev <= 4'h0;
      evt_pend <= 4'h0;
      overflow <= 1'b0;
    end else begin
      evt_prev <= evt_in;
      evt_pend <= (evt_pend & ~pend_clr & ~push_oh) | evt_rise;
      overflow <= (overflow & ~ovf_clr) | fifo_drop;
    end
  end

  rcd_evt_fifo #(
    .DEPTH (EVT_DEPTH),
    .WIDTH (2)
  ) u_evt_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_valid),
    .push_data (push_code),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IBI_IDLE;
      ibi_data_q <= 8'h00;
    end else begin
      state      <= next_state;
      ibi_data_q <= ibi_data_int;
    end
  end

  // IBI handshake: the head is popped on grant, then wait for grant to drop.
  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    case (state)
      IBI_IDLE: if (!fifo_empty) next_state = IBI_REQ;
      IBI_REQ: begin
        if (bus.ibi_grant) begin
          fifo_pop   = 1'b1;
          next_state = IBI_WAIT;
        end
      end
      IBI_WAIT: if (!bus.ibi_grant) next_state = IBI_IDLE;
      default:  next_state = IBI_IDLE;
    endcase
  end

  assign ibi_data_int    = (state == IBI_REQ) ? ibi_payload(fifo_head) : ibi_data_q;
  assign bus.ibi_request = (state == IBI_REQ);
  assign bus.ibi_data    = ibi_data_int;

endmodule

// File: tb/tb_rcd_cfg_reg_bank.sv
// Directed self-checking bench for rcd_cfg_reg_bank with hand-computed expectations.
module tb_rcd_cfg_reg_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   evt_in;
  logic [255:0] cfg_q;
  logic         err_flag;

  int checks   = 0;
  int failures = 0;

  logic       acc_ready, post_ready, acc_err, wait_ok;
  logic [7:0] acc_rdata, post_rdata;

  rcd_cfg_reg_bank_if bus ();

  rcd_cfg_reg_bank #(
    .NUM_CFG   (32),
    .EVT_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .evt_in   (evt_in),
    .cfg_q    (cfg_q),
    .err_flag (err_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One strobe cycle, then sample the response cycle and the cycle after it.
  task automatic bus_access(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.reg_addr  = addr;
    bus.reg_wdata = data;
    bus.reg_read  = rd;
    bus.reg_write = wr;
    @(negedge clk);
    acc_ready     = bus.reg_ready;
    acc_rdata     = bus.reg_rdata;
    acc_err       = err_flag;
    bus.reg_read  = 1'b0;
    bus.reg_write = 1'b0;
    @(negedge clk);
    post_ready = bus.reg_ready;
    post_rdata = bus.reg_rdata;
  endtask

  task automatic wait_request(input logic level);
    wait_ok = 1'b0;
    for (int i = 0; i < 40 && !wait_ok; i++) begin
      @(negedge clk);
      if (bus.ibi_request === level) wait_ok = 1'b1;
    end
  endtask

  task automatic grant_pulse();
    @(negedge clk);
    bus.ibi_grant = 1'b1;
    @(negedge clk);
    bus.ibi_grant = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.reg_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready: got %b expected 0", bus.reg_ready); end
    checks++; if (bus.reg_rdata !== 8'h00) begin failures++; $display("[TB] FAIL rst_rdata: got %h expected 00", bus.reg_rdata); end
    checks++; if (bus.ibi_request !== 1'b0) begin failures++; $display("[TB] FAIL rst_ibi_req: got %b expected 0", bus.ibi_request); end
    checks++; if (bus.ibi_data !== 8'h00) begin failures++; $display("[TB] FAIL rst_ibi_data: got %h expected 00", bus.ibi_data); end
    checks++; if (err_flag !== 1'b0) begin failures++; $display("[TB] FAIL rst_err: got %b expected 0", err_flag); end
    checks++; if (cfg_q !== 256'h0) begin failures++; $display("[TB] FAIL rst_cfg_q: got %h expected 0", cfg_q); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_access(1'b1, 1'b0, 8'h40, 8'h00);
    checks++; if (acc_rdata !== 8'h00) begin failures++; $display("[TB] FAIL rst_status: got %h expected 00", acc_rdata); end
    bus_access(1'b1, 1'b0, 8'h42, 8'h00);
    checks++; if (acc_rdata !== 8'h0F) begin failures++; $display("[TB] FAIL rst_mask: got %h expected 0f", acc_rdata); end
    bus_access(1'b1, 1'b0, 8'h7F, 8'h00);
    checks++; if (acc_rdata !== 8'h00) begin failures++; $display("[TB] FAIL rst_lock: got %h expected 00", acc_rdata); end
  endtask

  task automatic test_cfg_rw();
    bus_access(1'b0, 1'b1, 8'h05, 8'h3C);
    checks++; if (acc_ready !== 1'b1) begin failures++; $display("[TB] FAIL wr_ready: got %b expected 1", acc_ready); end
    checks++; if (post_ready !== 1'b0) begin failures++; $display("[TB] FAIL wr_ready_pulse: got %b expected 0", post_ready); end
    checks++; if (cfg_q[47:40] !== 8'h3C) begin failures++; $display("[TB] FAIL cfg_q_05: got %h expected 3c", cfg_q[47:40]); end
    checks++; if (acc_err !== 1'b0) begin failures++; $display("[TB] FAIL wr_err: got %b expected 0", acc_err); end
    bus_access(1'b1, 1'b0, 8'h05, 8'h00);
    checks++; if (acc_ready !== 1'b1) begin failures++; $display("[TB] FAIL rd_ready: got %b expected 1", acc_ready); end
    checks++; if (acc_rdata !== 8'h3C) begin failures++; $display("[TB] FAIL rd_05: got %h expected 3c", acc_rdata); end
    checks++; if (post_rdata !== 8'h00) begin failures++; $display("[TB] FAIL rd_idle_data: got %h expected 00", post_rdata); end
    bus_access(1'b0, 1'b1, 8'h1F, 8'h81);
    bus_access(1'b1, 1'b0, 8'h1F, 8'h00);
    checks++; if (acc_rdata !== 8'h81) begin failures++; $display("[TB] FAIL rd_1f: got %h expected 81", acc_rdata); end
    checks++; if (cfg_q[255:248] !== 8'h81) begin failures++; $display("[TB] FAIL cfg_q_1f: got %h expected 81", cfg_q[255:248]); end
  endtask

  task automatic test_lock();
    bus_access(1'b0, 1'b1, 8'h7F, 8'hA5);
    bus_access(1'b1, 1'b0, 8'h7F, 8'h00);
    checks++; if (acc_rdata !== 8'h01) begin failures++; $display("[TB] FAIL lock_read: got %h expected 01", acc_rdata); end
    bus_access(1'b0, 1'b1, 8'h00, 8'h11);
    checks++; if (acc_ready !== 1'b1) begin failures++; $display("[TB] FAIL locked_ready: got %b expected 1", acc_ready); end
    checks++; if (acc_err !== 1'b1) begin failures++; $display("[TB] FAIL locked_err: got %b expected 1", acc_err); end
    bus_access(1'b1, 1'b0, 8'h00, 8'h00);
    checks++; if (acc_rdata !== 8'h00) begin failures++; $display("[TB] FAIL locked_rd_00: got %h expected 00", acc_rdata); end
    bus_access(1'b0, 1'b1, 8'h40, 8'h01);
    checks++; if (acc_err !== 1'b0) begin failures++; $display("[TB] FAIL err_clear: got %b expected 0", acc_err); end
    bus_access(1'b0, 1'b1, 8'h7F, 8'h5A);
    bus_access(1'b0, 1'b1, 8'h7F, 8'h33);
    bus_access(1'b1, 1'b0, 8'h7F, 8'h00);
    checks++; if (acc_rdata !== 8'h00) begin failures++; $display("[TB] FAIL unlock_read: got %h expected 00", acc_rdata); end
    bus_access(1'b0, 1'b1, 8'h00, 8'h11);
    checks++; if (acc_err !== 1'b0) begin failures++; $display("[TB] FAIL unlocked_err: got %b expected 0", acc_err); end
    checks++; if (cfg_q[7:0] !== 8'h11) begin failures++; $display("[TB] FAIL cfg_q_00: got %h expected 11", cfg_q[7:0]); end
  endtask

  task automatic test_unmapped();
    bus_access(1'b1, 1'b0, 8'h30, 8'h00);
    checks++; if (acc_rdata !== 8'hFF) begin failures++; $display("[TB] FAIL unmap_rd_30: got %h expected ff", acc_rdata); end
    checks++; if (acc_err !== 1'b1) begin failures++; $display("[TB] FAIL unmap_err_30: got %b expected 1", acc_err); end
    bus_access(1'b0, 1'b1, 8'h40, 8'h01);
    checks++; if (err_flag !== 1'b0) begin failures++; $display("[TB] FAIL unmap_clr: got %b expected 0", err_flag); end
    bus_access(1'b1, 1'b0, 8'h20, 8'h00);
    checks++; if (acc_rdata !== 8'hFF) begin failures++; $display("[TB] FAIL unmap_rd_20: got %h expected ff", acc_rdata); end
    bus_access(1'b0, 1'b1, 8'h40, 8'h01);
    bus_access(1'b0, 1'b1, 8'h55, 8'hAA);
    checks++; if (acc_err !== 1'b1) begin failures++; $display("[TB] FAIL unmap_wr_err: got %b expected 1", acc_err); end
    bus_access(1'b0, 1'b1, 8'h40, 8'h01);
  endtask

  task automatic test_collision();
    bus_access(1'b1, 1'b1, 8'h03, 8'h77);
    checks++; if (acc_ready !== 1'b1) begin failures++; $display("[TB] FAIL coll_ready: got %b expected 1", acc_ready); end
    checks++; if (acc_rdata !== 8'h00) begin failures++; $display("[TB] FAIL coll_rdata: got %h expected 00", acc_rdata); end
    checks++; if (acc_err !== 1'b1) begin failures++; $display("[TB] FAIL coll_err: got %b expected 1", acc_err); end
    checks++; if (cfg_q[31:24] !== 8'h77) begin failures++; $display("[TB] FAIL coll_cfg_q: got %h expected 77", cfg_q[31:24]); end
    bus_access(1'b0, 1'b1, 8'h40, 8'h01);
  endtask

  task automatic test_mask();
    bus_access(1'b0, 1'b1, 8'h42, 8'h0E);
    @(negedge clk);
    evt_in = 4'b0001;
    repeat (5) @(negedge clk);
    checks++; if (bus.ibi_request !== 1'b0) begin failures++; $display("[TB] FAIL mask_no_ibi: got %b expected 0", bus.ibi_request); end
    bus_access(1'b1, 1'b0, 8'h41, 8'h00);
    checks++; if (acc_rdata !== 8'h01) begin failures++; $display("[TB] FAIL mask_pend: got %h expected 01", acc_rdata); end
    bus_access(1'b0, 1'b1, 8'h41, 8'h01);
    bus_access(1'b1, 1'b0, 8'h41, 8'h00);
    checks++; if (acc_rdata !== 8'h00) begin failures++; $display("[TB] FAIL pend_w1c: got %h expected 00", acc_rdata); end
    evt_in = 4'b0000;
    bus_access(1'b0, 1'b1, 8'h42, 8'h0F);
  endtask

  task automatic test_ibi_order();
    @(negedge clk);
    evt_in = 4'b0101;
    wait_request(1'b1);
    checks++; if (wait_ok !== 1'b1) begin failures++; $display("[TB] FAIL ibi_req1_timeout: got %b expected 1", wait_ok); end
    checks++; if (bus.ibi_data !== 8'hA0) begin failures++; $display("[TB] FAIL ibi_data_a0: got %h expected a0", bus.ibi_data); end
    grant_pulse();
    checks++; if (bus.ibi_request !== 1'b0) begin failures++; $display("[TB] FAIL ibi_wait_req: got %b expected 0", bus.ibi_request); end
    checks++; if (bus.ibi_data !== 8'hA0) begin failures++; $display("[TB] FAIL ibi_data_hold: got %h expected a0", bus.ibi_data); end
    wait_request(1'b1);
    checks++; if (wait_ok !== 1'b1) begin failures++; $display("[TB] FAIL ibi_req2_timeout: got %b expected 1", wait_ok); end
    checks++; if (bus.ibi_data !== 8'hA2) begin failures++; $display("[TB] FAIL ibi_data_a2: got %h expected a2", bus.ibi_data); end
    grant_pulse();
    evt_in = 4'b0000;
    repeat (3) @(negedge clk);
    bus_access(1'b1, 1'b0, 8'h40, 8'h00);
    checks++; if (acc_rdata !== 8'h00) begin failures++; $display("[TB] FAIL ibi_drained: got %h expected 00", acc_rdata); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'hA0, 8'hA1, 8'hA0, 8'hA1};
    @(negedge clk);
    evt_in = 4'b1111;
    @(negedge clk);
    evt_in = 4'b0000;
    @(negedge clk);
    evt_in = 4'b0011;
    repeat (8) @(negedge clk);
    bus_access(1'b1, 1'b0, 8'h40, 8'h00);
    checks++; if (acc_rdata !== 8'h9A) begin failures++; $display("[TB] FAIL ovf_status: got %h expected 9a", acc_rdata); end
    checks++; if (bus.ibi_data !== 8'hA0) begin failures++; $display("[TB] FAIL ovf_head: got %h expected a0", bus.ibi_data); end
    bus_access(1'b1, 1'b0, 8'h41, 8'h00);
    checks++; if (acc_rdata !== 8'h00) begin failures++; $display("[TB] FAIL ovf_pend: got %h expected 00", acc_rdata); end
    bus_access(1'b0, 1'b1, 8'h40, 8'h08);
    bus_access(1'b1, 1'b0, 8'h40, 8'h00);
    checks++; if (acc_rdata !== 8'h92) begin failures++; $display("[TB] FAIL ovf_clear: got %h expected 92", acc_rdata); end
    evt_in = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      wait_request(1'b1);
      checks++; if (wait_ok !== 1'b1) begin failures++; $display("[TB] FAIL drain_timeout_%0d: got %b expected 1", k, wait_ok); end
      checks++; if (bus.ibi_data !== exp_seq[k]) begin failures++; $display("[TB] FAIL drain_data_%0d: got %h expected %h", k, bus.ibi_data, exp_seq[k]); end
      grant_pulse();
    end
    repeat (3) @(negedge clk);
    bus_access(1'b1, 1'b0, 8'h40, 8'h00);
    checks++; if (acc_rdata !== 8'h00) begin failures++; $display("[TB] FAIL drain_status: got %h expected 00", acc_rdata); end
  endtask

  task automatic test_reset_ibi();
    @(negedge clk);
    evt_in = 4'b1000;
    wait_request(1'b1);
    checks++; if (wait_ok !== 1'b1) begin failures++; $display("[TB] FAIL rst_ibi_timeout: got %b expected 1", wait_ok); end
    @(negedge clk);
    rst_n         = 1'b0;
    bus.reg_addr  = 8'h40;
    bus.reg_read  = 1'b1;
    evt_in        = 4'b0000;
    #1;
    checks++; if (bus.ibi_request !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_req: got %b expected 0", bus.ibi_request); end
    checks++; if (bus.ibi_data !== 8'h00) begin failures++; $display("[TB] FAIL rst_mid_data: got %h expected 00", bus.ibi_data); end
    @(negedge clk);
    bus.reg_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (bus.reg_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_no_ready_%0d: got %b expected 0", k, bus.reg_ready); end
    end
    bus_access(1'b1, 1'b0, 8'h40, 8'h00);
    checks++; if (acc_rdata !== 8'h00) begin failures++; $display("[TB] FAIL rst_fifo_empty: got %h expected 00", acc_rdata); end
  endtask

  initial begin
    rst_n         = 1'b0;
    evt_in        = 4'b0000;
    bus.reg_addr  = 8'h00;
    bus.reg_wdata = 8'h00;
    bus.reg_read  = 1'b0;
    bus.reg_write = 1'b0;
    bus.ibi_grant = 1'b0;
    $display("[TB] starting rcd_cfg_reg_bank bench");
    test_reset();
    test_cfg_rw();
    test_lock();
    test_unmapped();
    test_collision();
    test_mask();
    test_ibi_order();
    test_overflow();
    test_reset_ibi();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rcd_cfg_reg_bank.md
RCD_CFG_REG_BANK -- requirements
Module: rcd_cfg_reg_bank

Interface
REQ-001 Parameter NUM_CFG, default 32: number of read/write config registers at addresses 0x00..NUM_CFG-1.
REQ-002 Parameter EVT_DEPTH, default 4: depth of the IBI event FIFO, a power of two.
REQ-003 clk  input  1  single clock; every flop is clocked on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 reg_addr  input  8  register address from the I3C slave interface.
REQ-006 reg_wdata  input  8  write data.
REQ-007 reg_write  input  1  one-cycle write strobe.
REQ-008 reg_read  input  1  one-cycle read strobe.
REQ-009 reg_rdata  output  8  read data, valid while reg_ready=1.
REQ-010 reg_ready  output  1  one-cycle access-complete pulse.
REQ-011 evt_in  input  4  event sources; a rising edge on bit i is event code i.
REQ-012 ibi_request  output  1  In-Band Interrupt request to the I3C slave.
REQ-013 ibi_grant  input  1  IBI grant, held high until the controller acknowledges.
REQ-014 ibi_data  output  8  IBI payload = {4'hA, 2'b00, event code}.
REQ-015 cfg_q  output  NUM_CFG*8  flattened config register contents; register n is at bits [8n+7:8n].
REQ-016 err_flag  output  1  sticky access error, cleared by a write of 1 to STATUS bit 0.

Function
REQ-017 Address map: 0x00..NUM_CFG-1 config RW; 0x40 STATUS; 0x41 EVT_PEND; 0x42 EVT_MASK; 0x7F LOCK; all other addresses are unmapped.
REQ-018 Access latency: reg_ready SHALL pulse exactly 1 cycle after a reg_read or reg_write strobe; reg_rdata is valid in that same cycle and is 0x00 at all other times.
REQ-019 Config write: the register updates on the strobe edge and cfg_q reflects the new value on the following cycle.
REQ-020 LOCK: writing 0xA5 sets lock and writing 0x5A clears it; any other value is ignored; a read returns {7'b0, lock}.
REQ-021 While lock=1, config writes are ignored, err_flag is set, and reg_ready still pulses.
REQ-022 An unmapped read returns 0xFF and sets err_flag; an unmapped write is discarded and sets err_flag.
REQ-023 If reg_read and reg_write are asserted in the same cycle, the write executes, the read is ignored, and err_flag is set.
REQ-024 STATUS read = {fifo_count[2:0], fifo_full, overflow, lock, ibi_busy, err_flag}; writing 1 to bit 0 clears err_flag and writing 1 to bit 3 clears overflow.
REQ-025 EVT_PEND: bit i is set on an evt_in[i] rising edge and cleared by writing 1 (W1C); a set on the same cycle as the clear wins.
REQ-026 An event is pushed to the FIFO only if the matching EVT_MASK bit is 1; EVT_MASK resets to 0x0F.
REQ-027 Multiple events in the same cycle are pushed lowest code first, one per cycle; pending edges are held in the EVT_PEND bits until pushed.
REQ-028 Push on a full FIFO drops the event and sets overflow; a simultaneous push and pop on a full FIFO both succeed.
REQ-029 IBI FSM states and transitions:
- IBI_IDLE -> IBI_REQ when the FIFO is non-empty.
- IBI_REQ: ibi_request=1 and ibi_data = FIFO head; on ibi_grant=1, pop the head and go to IBI_WAIT.
- IBI_WAIT: ibi_request=0; go to IBI_IDLE when ibi_grant=0.
REQ-030 ibi_busy = (state != IBI_IDLE); ibi_data holds its last value outside IBI_REQ.
REQ-031 FIFO pointers are log2(EVT_DEPTH) bits and wrap modulo EVT_DEPTH; the count is log2(EVT_DEPTH)+1 bits.

Reset
REQ-032 Reset values:
- config registers = 0x00; lock = 0; EVT_PEND = 0; EVT_MASK = 0x0F.
- FIFO empty; overflow = 0; err_flag = 0.
- IBI FSM = IBI_IDLE; evt_in edge-detect flops = 0.
- reg_ready = 0; reg_rdata = 0x00; ibi_request = 0; ibi_data = 0x00.
REQ-033 Reset asserted mid-access or mid-IBI SHALL abort immediately, and no reg_ready pulse follows reset release.

Structure
REQ-034 Package rcd_cfg_pkg SHALL hold the ibi_state_t enum, the address constants (0x40, 0x41, 0x42, 0x7F), the lock keys (0xA5, 0x5A), and the IBI payload prefix 4'hA.
REQ-035 The event FIFO SHALL be a separate sub-module, rcd_evt_fifo, parameterized by depth and width.

Verification
REQ-036 Write 0x3C to 0x05, then read 0x05 -> reg_ready 1 cycle after each strobe, reg_rdata=0x3C, cfg_q[47:40]=0x3C.
REQ-037 Write 0xA5 to 0x7F, write 0x11 to 0x00, then read 0x00 -> reg_rdata=0x00 and err_flag=1; write 0x5A to 0x7F, then write 0x11 to 0x00 -> write succeeds.
REQ-038 Read 0x30 -> reg_rdata=0xFF and err_flag=1; write 0x01 to 0x40 -> err_flag=0.
REQ-039 evt_in rises 4'b0101 in one cycle with ibi_grant tied 0 -> ibi_request=1 with ibi_data=0xA0; after a grant pulse, ibi_data=0xA2.
REQ-040 Six masked-in events with no grant -> the FIFO holds 4, overflow=1, and a STATUS read shows bit 4 (full) set.
REQ-041 rst_n asserted while in IBI_REQ -> ibi_request=0 in the same cycle; after release the FIFO is empty and the state is IBI_IDLE.
